// File: rtl/user_pkg.sv
// user_pkg: shared opcodes and state/source enums for the QSPI flash responder
package user_pkg;
  localparam logic [7:0] CmdRead     = 8'h03;
  localparam logic [7:0] CmdQuadRead = 8'h6B;
  localparam logic [7:0] CmdRdId     = 8'h9F;
  localparam logic [7:0] CmdRdSr     = 8'h05;
  typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE} qspi_rsp_state_e;
  typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_SR} qspi_rsp_src_e;
endpackage

// File: rtl/qspi_rsp_sampler.sv
// qspi_rsp_sampler: synchronizes SPI pins to clk_i and derives SCK edge pulses and an armed chip-select
module qspi_rsp_sampler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic [3:0] spi_d_i,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       cs_active,
  output logic [3:0] d_sync
);
  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] fill;
  logic [3:0] d_q;
  logic       armed;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q  <= 3'b000;
      cs_q   <= 2'b11;
      d_q    <= 4'h0;
      d_sync <= 4'h0;
      fill   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck_i};
      cs_q   <= {cs_q[0], spi_cs_ni};
      d_q    <= spi_d_i;
      d_sync <= d_q;
      fill   <= {fill[0], 1'b1};
      armed  <= armed | (fill[1] & cs_q[1]);
    end
  end
  assign cs_active = armed & ~cs_q[1];
  assign sck_rise  = cs_active & sck_q[1] & ~sck_q[2];
  assign sck_fall  = cs_active & ~sck_q[1] & sck_q[2];
endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: QSPI flash target serving 03h/6Bh reads, 9Fh ID and 05h status from a sync byte memory
module qspi_flash_responder
  import user_pkg::*;
#(
  parameter int          AddrWidth       = 24,
  parameter int          QuadDummyCycles = 8,
  parameter logic [23:0] JedecId         = 24'hEF4018
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_sck_i,
  input  logic                 spi_cs_ni,
  input  logic [3:0]           spi_d_i,
  output logic [3:0]           spi_d_o,
  output logic [3:0]           spi_d_oe_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [7:0]           mem_rdata_i
);
  logic            sck_rise, sck_fall, cs_active;
  logic [3:0]      d_s;
  logic            unused_d;
  qspi_rsp_state_e state, state_d;
  qspi_rsp_src_e   src;
  logic            quad, rd_pend, last_in, last_unit, byte_start;
  logic [4:0]      cnt;
  logic [22:0]     sr;
  logic [23:0]     addr_in;
  logic [7:0]      opc, buf_q, shreg, out_byte, id_byte;
  logic [1:0]      id_idx;
  logic [3:0]      d_q;

  qspi_rsp_sampler u_sampler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .spi_sck_i (spi_sck_i),
    .spi_cs_ni (spi_cs_ni),
    .spi_d_i   (spi_d_i),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .cs_active (cs_active),
    .d_sync    (d_s)
  );

  assign unused_d   = ^d_s[3:1];
  assign opc        = {sr[6:0], d_s[0]};
  assign addr_in    = {sr, d_s[0]};
  assign last_in    = cnt == (state == ST_CMD ? 5'd7 : state == ST_ADDR ? 5'd23 : 5'(QuadDummyCycles - 1));
  assign last_unit  = cnt == (quad ? 5'd1 : 5'd7);
  assign byte_start = cnt == 5'd0;
  assign out_byte   = byte_start ? buf_q : shreg;
  assign id_byte    = id_idx == 2'd0 ? JedecId[23:16] : id_idx == 2'd1 ? JedecId[15:8] : JedecId[7:0];
  assign spi_d_oe_o = (cs_active && state == ST_DATA) ? (quad ? 4'b1111 : 4'b0010) : 4'b0000;
  assign spi_d_o    = d_q & spi_d_oe_o;

  always_comb begin
    state_d = state;
    if (!cs_active)
      state_d = ST_CMD;
    else if (sck_rise && last_in)
      case (state)
        ST_CMD:   state_d = (opc == CmdRead || opc == CmdQuadRead) ? ST_ADDR :
                            (opc == CmdRdId || opc == CmdRdSr) ? ST_DATA : ST_IGNORE;
        ST_ADDR:  state_d = (quad && QuadDummyCycles != 0) ? ST_DUMMY : ST_DATA;
        ST_DUMMY: state_d = ST_DATA;
        default:  state_d = state;
      endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_CMD;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src        <= SRC_MEM;
      quad       <= 1'b0;
      rd_pend    <= 1'b0;
      cnt        <= 5'd0;
      sr         <= '0;
      buf_q      <= 8'h00;
      shreg      <= 8'h00;
      id_idx     <= 2'd0;
      d_q        <= 4'h0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      mem_req_o <= 1'b0;
      rd_pend   <= mem_req_o & cs_active;
      if (rd_pend && cs_active) buf_q <= mem_rdata_i;
      if (!cs_active) begin
        cnt     <= 5'd0;
        d_q     <= 4'h0;
        rd_pend <= 1'b0;
      end else if (sck_rise && (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY)) begin
        sr  <= {sr[21:0], d_s[0]};
        cnt <= last_in ? 5'd0 : cnt + 5'd1;
        if (last_in && state == ST_CMD) begin
          quad   <= opc == CmdQuadRead;
          src    <= opc == CmdRdId ? SRC_ID : opc == CmdRdSr ? SRC_SR : SRC_MEM;
          buf_q  <= opc == CmdRdId ? JedecId[23:16] : 8'h00;
          id_idx <= 2'd1;
        end
        if (last_in && state == ST_ADDR) begin
          mem_addr_o <= addr_in[AddrWidth-1:0];
          mem_req_o  <= 1'b1;
        end
      end else if (sck_fall && state == ST_DATA) begin
        d_q   <= quad ? out_byte[7:4] : {2'b00, out_byte[7], 1'b0};
        shreg <= quad ? {out_byte[3:0], 4'h0} : {out_byte[6:0], 1'b0};
        cnt   <= last_unit ? 5'd0 : cnt + 5'd1;
        if (byte_start && src == SRC_MEM) begin
          mem_addr_o <= mem_addr_o + AddrWidth'(1);
          mem_req_o  <= 1'b1;
        end
        if (byte_start && src != SRC_MEM) begin
          buf_q  <= src == SRC_ID ? id_byte : 8'h00;
          id_idx <= id_idx == 2'd2 ? 2'd0 : id_idx + 2'd1;
        end
      end
    end
  end
endmodule
